// File: rtl/rtable_arbiter.sv
// rtable_arbiter
//   Round-robin arbiter sharing one registered rtable read port among N_REQ
//   requesters. One lookup in flight: IDLE (grant) -> ISSUE (read strobe)
//   -> WAIT (capture data) -> RESP (hold until the owner accepts).
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/i_req_addr  per-requester lookup request, packed addresses
//   o_req_ready             one-hot grant, combinational, IDLE only
//   o_rt_addr/o_rt_read     registered rtable address and read strobe
//   i_rt_data               rtable data, valid the cycle after o_rt_read
//   o_rsp_valid/o_rsp_data  one-hot response valid, shared reward word
//   o_rsp_id                index of the responding requester
//   i_rsp_ready             per-requester response accept
//   o_busy                  high whenever the FSM is not IDLE
module rtable_arbiter #(
  parameter  int N_REQ      = 4,
  parameter  int ADDR_WIDTH = 19,
  parameter  int DATA_WIDTH = 32,
  localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [ADDR_WIDTH-1:0]       o_rt_addr,
  output logic                        o_rt_read,
  input  logic [DATA_WIDTH-1:0]       i_rt_data,
  output logic [N_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]       o_rsp_data,
  output logic [ID_W-1:0]             o_rsp_id,
  input  logic [N_REQ-1:0]            i_rsp_ready,
  output logic                        o_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   rt_addr_q, rt_addr_d;
  logic                    rt_read_q, rt_read_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic                    busy_q, busy_d;

  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  logic [N_REQ-1:0]        req_ready;
  logic                    grant;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(last_grant_q) + 32'd1 + i) % N_REQ;
      if (!win_found && i_req_valid[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end

  // Reset blocks the handshake so nothing is accepted in a reset cycle.
  assign grant = (state_q == S_IDLE) && win_found && !i_rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rt_addr_d    = rt_addr_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d      = S_ISSUE;
          last_grant_d = win_idx;
          rsp_id_d     = win_idx;
          rt_addr_d    = i_req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d    = S_RESP;
        rsp_data_d = i_rt_data;
      end
      S_RESP: begin
        if (i_rsp_ready[rsp_id_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they leave as flop outputs.
    rt_read_d   = (state_d == S_ISSUE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = '0;
    if (state_d == S_RESP) rsp_valid_d[rsp_id_d] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(N_REQ - 1);
      rt_addr_q    <= '0;
      rt_read_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rt_addr_q    <= rt_addr_d;
      rt_read_q    <= rt_read_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign o_req_ready = req_ready;
  assign o_rt_addr   = rt_addr_q;
  assign o_rt_read   = rt_read_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_rtable_arbiter.sv
// tb_rtable_arbiter
//   Directed checks of rtable_arbiter with a small synchronous rtable model.
module tb_rtable_arbiter;

  localparam int NR = 4;
  localparam int AW = 19;
  localparam int DW = 32;

  localparam logic [AW-1:0] A_GOAL = 19'b1111_1110_1111_1111_100;
  localparam logic [AW-1:0] A_DEF  = 19'b0101_0101_0101_0101_010;
  localparam logic [AW-1:0] A0     = 19'h00001;
  localparam logic [AW-1:0] A1     = 19'h00102;
  localparam logic [AW-1:0] A2     = 19'h00203;
  localparam logic [AW-1:0] A3     = 19'h00304;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_ready;
  logic [AW-1:0]    rt_addr;
  logic             rt_read;
  logic [DW-1:0]    rt_data;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic [1:0]       rsp_id;
  logic [NR-1:0]    rsp_ready;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rtable_arbiter #(.N_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .o_req_ready (req_ready),
    .o_rt_addr   (rt_addr),
    .o_rt_read   (rt_read),
    .i_rt_data   (rt_data),
    .o_rsp_valid (rsp_valid),
    .o_rsp_data  (rsp_data),
    .o_rsp_id    (rsp_id),
    .i_rsp_ready (rsp_ready),
    .o_busy      (busy)
  );

  function automatic logic [DW-1:0] rt_lookup(input logic [AW-1:0] a);
    case (a)
      A_GOAL:  return 32'h47800000;
      A0:      return 32'hBF800000;
      A1:      return 32'h3F800000;
      A2:      return 32'h40000000;
      A3:      return 32'hC1200000;
      default: return 32'h00000000;
    endcase
  endfunction

  // rtable model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rt_read) rt_data <= rt_lookup(rt_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [DW-1:0] exp_data [NR];
  int            exp_order [5];

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = '0;
    rt_data   = '0;
    exp_data  = '{32'hBF800000, 32'h3F800000, 32'h40000000, 32'hC1200000};
    exp_order = '{0, 1, 2, 3, 0};

    do_reset();
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rt_read",   64'(rt_read),   64'd0);
    check("rst_rt_addr",   64'(rt_addr),   64'd0);
    check("rst_rsp_id",    64'(rsp_id),    64'd0);
    check("rst_rsp_data",  64'(rsp_data),  64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);

    // Single lookup from requester 2.
    req_addr[2*AW +: AW] = A_GOAL;
    req_valid = 4'b0100;
    rsp_ready = 4'b1111;
    #1;
    check("single_c0_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    #1;
    check("single_c1_read",  64'(rt_read),   64'd1);
    check("single_c1_addr",  64'(rt_addr),   64'(A_GOAL));
    check("single_c1_busy",  64'(busy),      64'd1);
    tick();
    check("single_c2_read",  64'(rt_read),   64'd0);
    check("single_c2_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("single_c3_valid", 64'(rsp_valid), 64'b0100);
    check("single_c3_id",    64'(rsp_id),    64'd2);
    check("single_c3_data",  64'(rsp_data),  64'h47800000);
    tick();
    check("single_c4_busy",  64'(busy),      64'd0);
    check("single_c4_valid", 64'(rsp_valid), 64'd0);

    // Round-robin fairness with all requesters held valid.
    do_reset();
    req_addr  = {A3, A2, A1, A0};
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr%0d_ready", i), 64'(req_ready), 64'(4'b0001 << exp_order[i]));
      tick();
      check($sformatf("rr%0d_issue_noready", i), 64'(req_ready), 64'd0);
      tick();
      tick();
      check($sformatf("rr%0d_id", i),   64'(rsp_id),   64'(exp_order[i]));
      check($sformatf("rr%0d_data", i), 64'(rsp_data), 64'(exp_data[exp_order[i]]));
      tick();
    end
    req_valid = '0;

    // Backpressure: requester 1 holds off while requester 3 toggles ready.
    do_reset();
    req_addr  = {A3, A2, A1, A0};
    req_valid = 4'b0010;
    rsp_ready = 4'b0000;
    #1;
    check("bp_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = 4'b0001;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      rsp_ready = (k % 2 == 1) ? 4'b1000 : 4'b0000;
      #1;
      check($sformatf("bp%0d_valid", k), 64'(rsp_valid), 64'b0010);
      check($sformatf("bp%0d_data", k),  64'(rsp_data),  64'h3F800000);
      check($sformatf("bp%0d_ready", k), 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 4'b0010;
    #1;
    check("bp_accept_valid", 64'(rsp_valid), 64'b0010);
    tick();
    rsp_ready = 4'b1111;
    #1;
    check("bp_exit_busy",   64'(busy),      64'd0);
    check("bp_exit_valid",  64'(rsp_valid), 64'd0);
    check("bp_next_grant",  64'(req_ready), 64'b0001);

    // Default entry: requester 0 looks up an unwritten address.
    req_addr[0 +: AW] = A_DEF;
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("def_valid", 64'(rsp_valid), 64'b0001);
    check("def_data",  64'(rsp_data),  64'h00000000);
    tick();

    // Reset in WAIT aborts the lookup; reset also blocks a grant.
    req_addr  = {A3, A2, A1, A0};
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    tick();
    rst       = 1'b1;
    req_valid = 4'b1010;
    #1;
    check("rstmid_in_wait_ready", 64'(req_ready), 64'd0);
    tick();
    #1;
    check("rstmid_idle_gated_ready", 64'(req_ready), 64'd0);
    check("rstmid_busy",      64'(busy),      64'd0);
    check("rstmid_valid",     64'(rsp_valid), 64'd0);
    check("rstmid_rt_read",   64'(rt_read),   64'd0);
    check("rstmid_rsp_data",  64'(rsp_data),  64'd0);
    rst = 1'b0;
    #1;
    check("rstmid_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("rstmid_rsp_id",   64'(rsp_id),   64'd1);
    check("rstmid_rsp_data2", 64'(rsp_data), 64'h3F800000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
